ps2_move_decoder: RTL and testbench

//  Downstream of the PS/2 keyboard receiver. Consumes its four captured scan codes plus the move-enable level.

---
 rtl/ps2_chess_pkg.sv | 93 +++++++++
 rtl/ps2_move_decoder_if.sv | 36 +++
 rtl/ps2_sync_edge.sv | 45 ++++
 rtl/ps2_move_decoder.sv | 195 +++++++++++++++++++
 tb/tb_ps2_move_decoder.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_chess_pkg.sv
// ---------------------------------------------------------------------------
// ps2_chess_pkg
//   Shared definitions for the PS/2 chess-move path:
//     - PS/2 set-2 make codes of the keys used for files (a..h) and ranks (1..8)
//     - FSM state encoding of ps2_move_decoder
//     - error codes reported on err_code
//     - scan-code lookup functions returning {hit, 3-bit index}
// ---------------------------------------------------------------------------
package ps2_chess_pkg;

    // Set-2 make codes for the file letters a..h
    localparam logic [7:0] SC_FILE_A = 8'h1C;
    localparam logic [7:0] SC_FILE_B = 8'h32;
    localparam logic [7:0] SC_FILE_C = 8'h21;
    localparam logic [7:0] SC_FILE_D = 8'h23;
    localparam logic [7:0] SC_FILE_E = 8'h24;
    localparam logic [7:0] SC_FILE_F = 8'h2B;
    localparam logic [7:0] SC_FILE_G = 8'h34;
    localparam logic [7:0] SC_FILE_H = 8'h33;

    // Set-2 make codes for the digits 1..8
    localparam logic [7:0] SC_RANK_1 = 8'h16;
    localparam logic [7:0] SC_RANK_2 = 8'h1E;
    localparam logic [7:0] SC_RANK_3 = 8'h26;
    localparam logic [7:0] SC_RANK_4 = 8'h25;
    localparam logic [7:0] SC_RANK_5 = 8'h2E;
    localparam logic [7:0] SC_RANK_6 = 8'h36;
    localparam logic [7:0] SC_RANK_7 = 8'h3D;
    localparam logic [7:0] SC_RANK_8 = 8'h3E;

    // err_code values; 3 is shared by engine timeout and user cancel
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BADKEY   = 2'd1;
    localparam logic [1:0] ERR_NULLMOVE = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURE  = 3'd1,
        ST_DECODE   = 3'd2,
        ST_CHECK    = 3'd3,
        ST_OFFER    = 3'd4,
        ST_ERR      = 3'd5,
        ST_WAIT_CLR = 3'd6
    } state_e;

    // Lookup result: hit=1 when the scan code belongs to the class
    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } lut_res_t;

    function automatic lut_res_t decode_file(input logic [7:0] sc);
        lut_res_t r;
        r.hit = 1'b1;
        case (sc)
            SC_FILE_A: r.idx = 3'd0;
            SC_FILE_B: r.idx = 3'd1;
            SC_FILE_C: r.idx = 3'd2;
            SC_FILE_D: r.idx = 3'd3;
            SC_FILE_E: r.idx = 3'd4;
            SC_FILE_F: r.idx = 3'd5;
            SC_FILE_G: r.idx = 3'd6;
            SC_FILE_H: r.idx = 3'd7;
            default: begin
                r.hit = 1'b0;
                r.idx = 3'd0;
            end
        endcase
        return r;
    endfunction

    function automatic lut_res_t decode_rank(input logic [7:0] sc);
        lut_res_t r;
        r.hit = 1'b1;
        case (sc)
            SC_RANK_1: r.idx = 3'd0;
            SC_RANK_2: r.idx = 3'd1;
            SC_RANK_3: r.idx = 3'd2;
            SC_RANK_4: r.idx = 3'd3;
            SC_RANK_5: r.idx = 3'd4;
            SC_RANK_6: r.idx = 3'd5;
            SC_RANK_7: r.idx = 3'd6;
            SC_RANK_8: r.idx = 3'd7;
            default: begin
                r.hit = 1'b0;
                r.idx = 3'd0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_move_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_move_decoder_if
//   Bundles the receiver-side inputs (move_en, key1..key4), the engine
//   handshake (move_valid/move_ready) and the status outputs of the decoder.
//   master : the decoder (drives move offer and status)
//   slave  : the environment (receiver + engine)
// ---------------------------------------------------------------------------
interface ps2_move_decoder_if;
    logic       move_en;
    logic [7:0] key1;
    logic [7:0] key2;
    logic [7:0] key3;
    logic [7:0] key4;
    logic       move_ready;
    logic       move_valid;
    logic [2:0] from_file;
    logic [2:0] from_rank;
    logic [2:0] to_file;
    logic [2:0] to_rank;
    logic       err_pulse;
    logic [1:0] err_code;
    logic       busy;
    logic [7:0] move_count;

    modport master (
        input  move_en, key1, key2, key3, key4, move_ready,
        output move_valid, from_file, from_rank, to_file, to_rank,
               err_pulse, err_code, busy, move_count
    );

    modport slave (
        output move_en, key1, key2, key3, key4, move_ready,
        input  move_valid, from_file, from_rank, to_file, to_rank,
               err_pulse, err_code, busy, move_count
    );
endinterface

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
//   STAGES-flop synchroniser for a level from another clock domain, plus
//   single-cycle rise/fall pulses derived from the synchronised level.
//   Ports: clk, rst_n (async active-low), async_i (raw level),
//          level_o (synced level), rise_o / fall_o (edge pulses).
// ---------------------------------------------------------------------------
module ps2_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // Shift the raw level through the chain; remember last synced level
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_i};
        prev_d = sync_q[STAGES-1];
    end

    // Synchroniser and edge-history flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ps2_move_decoder.sv
// ---------------------------------------------------------------------------
// ps2_move_decoder
//   Turns four captured PS/2 set-2 scan codes ("e2e4") into board coordinates,
//   rejects unknown keys and null moves, and offers the move to the engine
//   over a valid/ready handshake.
//   Ports: clk, rst_n (async active-low)
//          bus (master): move_en, key1..key4, move_ready in;
//                        move_valid, from/to file/rank, err_pulse, err_code,
//                        busy, move_count out.
//   Parameters: SYNC_STAGES (move_en synchroniser depth, >=2)
//               TIMEOUT_CYC (max offer cycles, 0 = wait forever)
// ---------------------------------------------------------------------------
module ps2_move_decoder
    import ps2_chess_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    ps2_move_decoder_if.master bus
);

    // Counter needs at least one bit even when the timeout is disabled
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYC);

    state_e          state_q, state_d;
    logic [3:0][7:0] key_q, key_d;
    logic [2:0]      from_file_q, from_file_d;
    logic [2:0]      from_rank_q, from_rank_d;
    logic [2:0]      to_file_q, to_file_d;
    logic [2:0]      to_rank_q, to_rank_d;
    logic            move_valid_q, move_valid_d;
    logic            err_pulse_q, err_pulse_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            busy_q, busy_d;
    logic [7:0]      move_count_q, move_count_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic     en_level_s;
    logic     en_rise_s;
    logic     en_fall_s;
    logic     cancel_s;
    lut_res_t ff_s, fr_s, tf_s, tr_s;
    logic     all_hit_s;

    ps2_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (bus.move_en),
        .level_o (en_level_s),
        .rise_o  (en_rise_s),
        .fall_o  (en_fall_s)
    );

    // The fall pulse catches a release during OFFER; the low level also
    // catches a release that happened while still decoding, which would
    // otherwise leave the offer hanging with no edge left to see.
    assign cancel_s = en_fall_s | ~en_level_s;

    // Scan-code lookup on the captured keys
    assign ff_s      = decode_file(key_q[0]);
    assign fr_s      = decode_rank(key_q[1]);
    assign tf_s      = decode_file(key_q[2]);
    assign tr_s      = decode_rank(key_q[3]);
    assign all_hit_s = ff_s.hit & fr_s.hit & tf_s.hit & tr_s.hit;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        from_file_d  = from_file_q;
        from_rank_d  = from_rank_q;
        to_file_d    = to_file_q;
        to_rank_d    = to_rank_q;
        err_code_d   = err_code_q;
        move_count_d = move_count_q;
        tmo_cnt_d    = tmo_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (en_rise_s) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                key_d   = {bus.key4, bus.key3, bus.key2, bus.key1};
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (all_hit_s) begin
                    from_file_d = ff_s.idx;
                    from_rank_d = fr_s.idx;
                    to_file_d   = tf_s.idx;
                    to_rank_d   = tr_s.idx;
                    state_d     = ST_CHECK;
                end else begin
                    err_code_d = ERR_BADKEY;
                    state_d    = ST_ERR;
                end
            end
            ST_CHECK: begin
                if ((from_file_q == to_file_q) && (from_rank_q == to_rank_q)) begin
                    err_code_d = ERR_NULLMOVE;
                    state_d    = ST_ERR;
                end else begin
                    tmo_cnt_d = '0;
                    state_d   = ST_OFFER;
                end
            end
            ST_OFFER: begin
                // Priority: handshake, then cancel, then timeout
                if (bus.move_ready) begin
                    move_count_d = move_count_q + 8'd1;
                    state_d      = ST_WAIT_CLR;
                end else if (cancel_s) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_ERR;
                end else if ((TIMEOUT_CYC > 0) && ((tmo_cnt_q + TW'(1)) == TMO_LIMIT)) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_ERR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                    state_d   = ST_OFFER;
                end
            end
            ST_ERR: begin
                state_d = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                // Receiver keeps move_en high until backspace; one move per level
                if (!en_level_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_CLR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of the state being entered
        move_valid_d = (state_d == ST_OFFER);
        err_pulse_d  = (state_d == ST_ERR);
        busy_d       = (state_d != ST_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            from_file_q  <= 3'd0;
            from_rank_q  <= 3'd0;
            to_file_q    <= 3'd0;
            to_rank_q    <= 3'd0;
            move_valid_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            busy_q       <= 1'b0;
            move_count_q <= 8'd0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            from_file_q  <= from_file_d;
            from_rank_q  <= from_rank_d;
            to_file_q    <= to_file_d;
            to_rank_q    <= to_rank_d;
            move_valid_q <= move_valid_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
            busy_q       <= busy_d;
            move_count_q <= move_count_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign bus.move_valid = move_valid_q;
    assign bus.from_file  = from_file_q;
    assign bus.from_rank  = from_rank_q;
    assign bus.to_file    = to_file_q;
    assign bus.to_rank    = to_rank_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_code   = err_code_q;
    assign bus.busy       = busy_q;
    assign bus.move_count = move_count_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_move_decoder
//   Directed tests for ps2_move_decoder. dut0 has no timeout, dut1 has a
//   10-cycle timeout. Inputs change 1 time unit after posedge, outputs are
//   sampled at the same point.
// ---------------------------------------------------------------------------
module tb_ps2_move_decoder;

    logic clk = 1'b0;
    logic rst_n;

    ps2_move_decoder_if bus0 ();
    ps2_move_decoder_if bus1 ();

    ps2_move_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    ps2_move_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYC(10)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen0 = 0;
    int err_seen1 = 0;
    int exp_count = 0;

    // Count err_pulse strobes (one-cycle pulses, one negedge each)
    always @(negedge clk) begin
        if (bus0.err_pulse === 1'b1) err_seen0 <= err_seen0 + 1;
        if (bus1.err_pulse === 1'b1) err_seen1 <= err_seen1 + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_keys0(input logic [7:0] k1, k2, k3, k4);
        bus0.key1 = k1; bus0.key2 = k2; bus0.key3 = k3; bus0.key4 = k4;
    endtask

    // Steps until move_valid; n = step index, or limit+1 if never seen
    task automatic wait_valid0(input int limit, output int n);
        n = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (bus0.move_valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_idle0(output int n);
        n = 21;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus0.busy === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_checks++; if (bus0.move_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus0.move_valid); end
        n_checks++; if ({bus0.from_file, bus0.from_rank, bus0.to_file, bus0.to_rank} !== 12'd0) begin n_fail++; $display("FAIL reset_coords: got %h want 000", {bus0.from_file, bus0.from_rank, bus0.to_file, bus0.to_rank}); end
        n_checks++; if (bus0.err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse: got %b want 0", bus0.err_pulse); end
        n_checks++; if (bus0.err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d want 0", bus0.err_code); end
        n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
        n_checks++; if (bus0.move_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus0.move_count); end
        rst_n = 1'b1;
        step(); step();
        n_checks++; if ({bus1.move_valid, bus1.busy, bus0.busy, bus0.move_valid} !== 4'b0000) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0000", {bus1.move_valid, bus1.busy, bus0.busy, bus0.move_valid}); end
    endtask

    task automatic test_e2e4();
        int n;
        int base;
        base = err_seen0;
        set_keys0(8'h24, 8'h1E, 8'h24, 8'h25);
        bus0.move_ready = 1'b1;          // ready outside OFFER must be ignored
        step(); step(); step();
        bus0.move_en = 1'b1;
        wait_valid0(12, n);
        // 2 sync flops + edge detect + CAPTURE/DECODE/CHECK
        n_checks++; if (n != 6) begin n_fail++; $display("FAIL e2e4_latency: got %0d want 6", n); end
        n_checks++; if ({bus0.from_file, bus0.from_rank, bus0.to_file, bus0.to_rank} !== {3'd4, 3'd1, 3'd4, 3'd3}) begin n_fail++; $display("FAIL e2e4_coords: got %h want %h", {bus0.from_file, bus0.from_rank, bus0.to_file, bus0.to_rank}, {3'd4, 3'd1, 3'd4, 3'd3}); end
        n_checks++; if (bus0.move_count !== 8'd0 || bus0.busy !== 1'b1) begin n_fail++; $display("FAIL e2e4_pre_count: got count %0d busy %b want 0 1", bus0.move_count, bus0.busy); end
        step();
        exp_count = 1;
        n_checks++; if (bus0.move_valid !== 1'b0 || bus0.move_count !== 8'(exp_count)) begin n_fail++; $display("FAIL e2e4_handshake: got valid %b count %0d want 0 %0d", bus0.move_valid, bus0.move_count, exp_count); end
        step(); step(); step();
        n_checks++; if (bus0.move_count !== 8'(exp_count) || bus0.move_valid !== 1'b0) begin n_fail++; $display("FAIL e2e4_no_reissue: got count %0d valid %b want %0d 0", bus0.move_count, bus0.move_valid, exp_count); end
        bus0.move_en = 1'b0;
        wait_idle0(n);
        n_checks++; if (n != 3) begin n_fail++; $display("FAIL e2e4_idle: got %0d cycles want 3", n); end
        n_checks++; if ({bus0.from_file, bus0.from_rank, bus0.to_file, bus0.to_rank} !== {3'd4, 3'd1, 3'd4, 3'd3}) begin n_fail++; $display("FAIL e2e4_coord_hold: got %h", {bus0.from_file, bus0.from_rank, bus0.to_file, bus0.to_rank}); end
        n_checks++; if (err_seen0 != base) begin n_fail++; $display("FAIL e2e4_no_err: got %0d pulses want 0", err_seen0 - base); end
        bus0.move_ready = 1'b0;
    endtask

    // Shared body for the two decode-stage error cases
    task automatic run_err_case(input string name, input logic [7:0] k1, k2, k3, k4,
                                input logic [1:0] want_code);
        int n;
        int base;
        logic vld_seen;
        base = err_seen0;
        vld_seen = 1'b0;
        set_keys0(k1, k2, k3, k4);
        bus0.move_ready = 1'b1;
        bus0.move_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (bus0.move_valid === 1'b1) vld_seen = 1'b1;
        end
        n_checks++; if (vld_seen !== 1'b0) begin n_fail++; $display("FAIL %s_no_offer: move_valid seen", name); end
        n_checks++; if (err_seen0 - base != 1) begin n_fail++; $display("FAIL %s_pulses: got %0d want 1", name, err_seen0 - base); end
        n_checks++; if (bus0.err_code !== want_code || bus0.busy !== 1'b1) begin n_fail++; $display("FAIL %s_code: got code %0d busy %b want %0d 1", name, bus0.err_code, bus0.busy, want_code); end
        bus0.move_en = 1'b0;
        wait_idle0(n);
        n_checks++; if (n > 20 || bus0.err_code !== want_code || bus0.move_count !== 8'(exp_count)) begin n_fail++; $display("FAIL %s_idle: got %0d cycles code %0d count %0d", name, n, bus0.err_code, bus0.move_count); end
        bus0.move_ready = 1'b0;
    endtask

    task automatic test_badkey();
        run_err_case("badkey", 8'h1C, 8'h5A, 8'h24, 8'h25, 2'd1);
    endtask

    task automatic test_nullmove();
        run_err_case("nullmove", 8'h1C, 8'h16, 8'h1C, 8'h16, 2'd2);
    endtask

    task automatic test_cancel();
        int n;
        int base;
        int vcnt;
        set_keys0(8'h23, 8'h1E, 8'h23, 8'h25);
        bus0.move_ready = 1'b0;
        bus0.move_en = 1'b1;
        wait_valid0(12, n);
        n_checks++; if (n != 6 || {bus0.from_file, bus0.from_rank, bus0.to_file, bus0.to_rank} !== {3'd3, 3'd1, 3'd3, 3'd3}) begin n_fail++; $display("FAIL d2d4_offer: got latency %0d coords %h", n, {bus0.from_file, bus0.from_rank, bus0.to_file, bus0.to_rank}); end
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus0.move_valid === 1'b1) vcnt++;
        end
        n_checks++; if (vcnt != 20) begin n_fail++; $display("FAIL no_timeout_hold: got %0d valid cycles want 20", vcnt); end
        base = err_seen0;
        bus0.move_en = 1'b0;
        n = 11;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (bus0.err_pulse === 1'b1) begin n = i; break; end
        end
        n_checks++; if (n != 3) begin n_fail++; $display("FAIL cancel_timing: got %0d want 3", n); end
        n_checks++; if (bus0.move_valid !== 1'b0 || bus0.err_code !== 2'd3 || bus0.move_count !== 8'(exp_count)) begin n_fail++; $display("FAIL cancel_state: got valid %b code %0d count %0d want 0 3 %0d", bus0.move_valid, bus0.err_code, bus0.move_count, exp_count); end
        wait_idle0(n);
        n_checks++; if (n > 20 || err_seen0 - base != 1) begin n_fail++; $display("FAIL cancel_idle: got %0d cycles %0d pulses", n, err_seen0 - base); end
    endtask

    task automatic test_ready_fall_same();
        int n;
        int base;
        base = err_seen0;
        set_keys0(8'h34, 8'h16, 8'h2B, 8'h26);
        bus0.move_ready = 1'b0;
        bus0.move_en = 1'b1;
        wait_valid0(12, n);
        step();
        bus0.move_en = 1'b0;
        step(); step();              // synced level now low: this OFFER cycle sees the fall
        bus0.move_ready = 1'b1;
        step();
        bus0.move_ready = 1'b0;
        exp_count = exp_count + 1;
        n_checks++; if (bus0.move_valid !== 1'b0 || bus0.move_count !== 8'(exp_count) || bus0.err_pulse !== 1'b0) begin n_fail++; $display("FAIL ready_fall: got valid %b count %0d pulse %b want 0 %0d 0", bus0.move_valid, bus0.move_count, bus0.err_pulse, exp_count); end
        wait_idle0(n);
        n_checks++; if (n > 20 || err_seen0 != base || bus0.err_code !== 2'd3) begin n_fail++; $display("FAIL ready_fall_idle: got %0d cycles %0d pulses code %0d", n, err_seen0 - base, bus0.err_code); end
        n_checks++; if ({bus0.from_file, bus0.from_rank, bus0.to_file, bus0.to_rank} !== {3'd6, 3'd0, 3'd5, 3'd2}) begin n_fail++; $display("FAIL g1f3_coords: got %h want %h", {bus0.from_file, bus0.from_rank, bus0.to_file, bus0.to_rank}, {3'd6, 3'd0, 3'd5, 3'd2}); end
    endtask

    task automatic test_corner_coords();
        int n;
        set_keys0(8'h33, 8'h3E, 8'h1C, 8'h16);
        bus0.move_ready = 1'b1;
        bus0.move_en = 1'b1;
        wait_valid0(12, n);
        n_checks++; if (n > 12 || {bus0.from_file, bus0.from_rank, bus0.to_file, bus0.to_rank} !== {3'd7, 3'd7, 3'd0, 3'd0}) begin n_fail++; $display("FAIL h8a1_coords: got %h want %h", {bus0.from_file, bus0.from_rank, bus0.to_file, bus0.to_rank}, {3'd7, 3'd7, 3'd0, 3'd0}); end
        step();
        exp_count = exp_count + 1;
        bus0.move_en = 1'b0;
        wait_idle0(n);
        n_checks++; if (bus0.move_count !== 8'(exp_count)) begin n_fail++; $display("FAIL h8a1_count: got %0d want %0d", bus0.move_count, exp_count); end
        bus0.move_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        int vcnt;
        int base;
        base = err_seen1;
        bus1.key1 = 8'h24; bus1.key2 = 8'h1E; bus1.key3 = 8'h24; bus1.key4 = 8'h25;
        bus1.move_ready = 1'b0;
        bus1.move_en = 1'b1;
        n = 13;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (bus1.move_valid === 1'b1) begin n = i; break; end
        end
        vcnt = 1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus1.move_valid === 1'b1) vcnt++;
            else break;
        end
        n_checks++; if (n != 6 || vcnt != 10) begin n_fail++; $display("FAIL timeout_len: got latency %0d valid cycles %0d want 6 10", n, vcnt); end
        n_checks++; if (bus1.err_pulse !== 1'b1 || bus1.err_code !== 2'd3) begin n_fail++; $display("FAIL timeout_err: got pulse %b code %0d want 1 3", bus1.err_pulse, bus1.err_code); end
        bus1.move_en = 1'b0;
        n = 21;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus1.busy === 1'b0) begin n = i; break; end
        end
        n_checks++; if (n > 20 || err_seen1 - base != 1 || bus1.move_count !== 8'd0) begin n_fail++; $display("FAIL timeout_idle: got %0d cycles %0d pulses count %0d", n, err_seen1 - base, bus1.move_count); end
    endtask

    task automatic test_reset_mid_offer();
        int n;
        int base;
        set_keys0(8'h24, 8'h1E, 8'h24, 8'h25);
        bus0.move_ready = 1'b0;
        bus0.move_en = 1'b1;
        wait_valid0(12, n);
        step();
        base = err_seen0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (n > 12 || bus0.move_valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.move_count !== 8'd0) begin n_fail++; $display("FAIL rst_offer_async: got valid %b busy %b count %0d want 0 0 0", bus0.move_valid, bus0.busy, bus0.move_count); end
        n_checks++; if (bus0.err_pulse !== 1'b0 || bus0.err_code !== 2'd0 || {bus0.from_file, bus0.from_rank, bus0.to_file, bus0.to_rank} !== 12'd0) begin n_fail++; $display("FAIL rst_offer_status: got pulse %b code %0d coords %h", bus0.err_pulse, bus0.err_code, {bus0.from_file, bus0.from_rank, bus0.to_file, bus0.to_rank}); end
        bus0.move_en = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        exp_count = 0;
        n_checks++; if (bus0.busy !== 1'b0 || err_seen0 != base) begin n_fail++; $display("FAIL rst_offer_after: got busy %b pulses %0d", bus0.busy, err_seen0 - base); end
    endtask

    task automatic test_wrap();
        int n;
        int bad;
        bad = 0;
        bus0.move_ready = 1'b1;
        for (int m = 0; m < 256; m++) begin
            if (m % 2 == 0) set_keys0(8'h24, 8'h1E, 8'h24, 8'h25);
            else            set_keys0(8'h32, 8'h3D, 8'h21, 8'h2E);
            bus0.move_en = 1'b1;
            wait_valid0(12, n);
            if (n > 12) bad++;
            step();
            bus0.move_en = 1'b0;
            wait_idle0(n);
            if (n > 20) bad++;
            if (m == 254) begin
                n_checks++; if (bus0.move_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", bus0.move_count); end
            end
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wrap_moves: got %0d stalled moves want 0", bad); end
        n_checks++; if (bus0.move_count !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", bus0.move_count); end
        bus0.move_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.move_en = 1'b0; bus0.move_ready = 1'b0; set_keys0(8'h00, 8'h00, 8'h00, 8'h00);
        bus1.move_en = 1'b0; bus1.move_ready = 1'b0;
        bus1.key1 = 8'h00; bus1.key2 = 8'h00; bus1.key3 = 8'h00; bus1.key4 = 8'h00;
        test_reset();
        test_e2e4();
        test_badkey();
        test_nullmove();
        test_cancel();
        test_ready_fall_same();
        test_corner_coords();
        test_timeout();
        test_reset_mid_offer();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
